// File: rtl/ext_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester external bus arbiter.
package ext_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          TIMEOUT_DEFAULT = 255;
  localparam logic [15:0] TIMEOUT_RDATA   = 16'h0000;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  be;
    logic        rw;
    logic [15:0] wdata;
  } req_t;

endpackage

// File: rtl/ext_bus_arbiter.sv
// Round-robin arbiter sharing one downstream bus between two requesters,
// with a BUSY-cycle watchdog that completes stuck transfers and flags an IRQ.
module ext_bus_arbiter
  import ext_bus_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        m0_bus_enable,
  input  logic [15:0] m0_address,
  input  logic [1:0]  m0_byte_enable,
  input  logic        m0_rw,
  input  logic [15:0] m0_write_data,
  output logic        m0_acknowledge,
  output logic [15:0] m0_read_data,
  input  logic        m1_bus_enable,
  input  logic [15:0] m1_address,
  input  logic [1:0]  m1_byte_enable,
  input  logic        m1_rw,
  input  logic [15:0] m1_write_data,
  output logic        m1_acknowledge,
  output logic [15:0] m1_read_data,
  output logic [15:0] s_address,
  output logic [1:0]  s_byte_enable,
  output logic        s_rw,
  output logic [15:0] s_write_data,
  output logic        s_bus_enable,
  input  logic        s_acknowledge,
  input  logic [15:0] s_read_data,
  output logic        timeout_irq,
  input  logic        timeout_clear
);

  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT - 1);

  state_t            state, state_nxt;
  req_t [1:0]        req;
  req_t              s_req;
  logic [1:0]        bus_en;
  logic [1:0]        m_ack;
  logic [1:0][15:0]  m_rdata;
  logic              grant, last_grant, pick;
  logic [15:0]       busy_cnt;
  logic              ack_ok, to_hit;

  assign req[0] = '{addr: m0_address, be: m0_byte_enable, rw: m0_rw, wdata: m0_write_data};
  assign req[1] = '{addr: m1_address, be: m1_byte_enable, rw: m1_rw, wdata: m1_write_data};
  assign bus_en = {m1_bus_enable, m0_bus_enable};

  // On a tie the side that did not win last time gets the bus.
  always_comb begin
    pick = 1'b0;
    case (bus_en)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant;
      default: pick = 1'b0;
    endcase
  end

  // Downstream ack beats the watchdog when both land in the same cycle.
  assign ack_ok = (state == BUSY) && s_acknowledge;
  assign to_hit = (state == BUSY) && !s_acknowledge && (busy_cnt == CNT_LIMIT);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus_en) state_nxt = BUSY;
      BUSY:    if (ack_ok || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      busy_cnt     <= '0;
      s_req        <= '0;
      s_bus_enable <= 1'b0;
      m_ack        <= '0;
      m_rdata      <= '0;
      timeout_irq  <= 1'b0;
    end else begin
      m_ack <= '0;
      case (state)
        IDLE: if (|bus_en) begin
          grant        <= pick;
          s_req        <= req[pick];
          s_bus_enable <= 1'b1;
          busy_cnt     <= '0;
        end
        BUSY: begin
          busy_cnt <= busy_cnt + 16'd1;
          if (ack_ok || to_hit) begin
            s_bus_enable   <= 1'b0;
            m_ack[grant]   <= 1'b1;
            m_rdata[grant] <= ack_ok ? s_read_data : TIMEOUT_RDATA;
          end
        end
        DONE:    last_grant <= grant;
        default: ;
      endcase
      if (to_hit)             timeout_irq <= 1'b1;
      else if (timeout_clear) timeout_irq <= 1'b0;
    end
  end

  assign s_address      = s_req.addr;
  assign s_byte_enable  = s_req.be;
  assign s_rw           = s_req.rw;
  assign s_write_data   = s_req.wdata;
  assign m0_acknowledge = m_ack[0];
  assign m1_acknowledge = m_ack[1];
  assign m0_read_data   = m_rdata[0];
  assign m1_read_data   = m_rdata[1];

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench for ext_bus_arbiter: read, write, tie alternation, timeout and reset.
module tb_ext_bus_arbiter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        m0_bus_enable, m0_rw, m0_acknowledge;
  logic [15:0] m0_address, m0_write_data, m0_read_data;
  logic [1:0]  m0_byte_enable;
  logic        m1_bus_enable, m1_rw, m1_acknowledge;
  logic [15:0] m1_address, m1_write_data, m1_read_data;
  logic [1:0]  m1_byte_enable;
  logic [15:0] s_address, s_write_data, s_read_data;
  logic [1:0]  s_byte_enable;
  logic        s_rw, s_bus_enable, s_acknowledge;
  logic        timeout_irq, timeout_clear;

  int total = 0;
  int bad   = 0;

  ext_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_bus_enable(m0_bus_enable), .m0_address(m0_address), .m0_byte_enable(m0_byte_enable),
    .m0_rw(m0_rw), .m0_write_data(m0_write_data), .m0_acknowledge(m0_acknowledge),
    .m0_read_data(m0_read_data),
    .m1_bus_enable(m1_bus_enable), .m1_address(m1_address), .m1_byte_enable(m1_byte_enable),
    .m1_rw(m1_rw), .m1_write_data(m1_write_data), .m1_acknowledge(m1_acknowledge),
    .m1_read_data(m1_read_data),
    .s_address(s_address), .s_byte_enable(s_byte_enable), .s_rw(s_rw),
    .s_write_data(s_write_data), .s_bus_enable(s_bus_enable),
    .s_acknowledge(s_acknowledge), .s_read_data(s_read_data),
    .timeout_irq(timeout_irq), .timeout_clear(timeout_clear)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic test_reset();
    reset_reset_n = 1'b0;
    {m0_bus_enable, m0_rw, m1_bus_enable, m1_rw, s_acknowledge, timeout_clear} = '0;
    {m0_address, m0_write_data, m1_address, m1_write_data, s_read_data} = '0;
    m0_byte_enable = 2'b00; m1_byte_enable = 2'b00;
    repeat (2) @(negedge clk_clk);
    total++;
    if ({s_bus_enable, s_address, s_byte_enable, s_rw, s_write_data} !== 36'h0)
      begin bad++; $display("FAIL reset_s got=%h exp=0", {s_bus_enable, s_address, s_byte_enable, s_rw, s_write_data}); end
    total++;
    if ({m0_acknowledge, m1_acknowledge, m0_read_data, m1_read_data, timeout_irq} !== 35'h0)
      begin bad++; $display("FAIL reset_m got=%h exp=0", {m0_acknowledge, m1_acknowledge, m0_read_data, m1_read_data, timeout_irq}); end
    reset_reset_n = 1'b1;
  endtask

  task automatic test_read();
    @(negedge clk_clk);
    m0_address = 16'h2002; m0_rw = 1'b1; m0_byte_enable = 2'b11; m0_bus_enable = 1'b1;
    @(negedge clk_clk);
    total++; if (s_bus_enable !== 1'b1) begin bad++; $display("FAIL rd_sbe got=%b exp=1", s_bus_enable); end
    total++; if (s_address !== 16'h2002) begin bad++; $display("FAIL rd_addr got=%h exp=2002", s_address); end
    total++; if (s_rw !== 1'b1) begin bad++; $display("FAIL rd_rw got=%b exp=1", s_rw); end
    repeat (3) @(negedge clk_clk);
    s_acknowledge = 1'b1; s_read_data = 16'h0080;
    @(negedge clk_clk);
    total++; if (m0_acknowledge !== 1'b1) begin bad++; $display("FAIL rd_ack0 got=%b exp=1", m0_acknowledge); end
    total++; if (m1_acknowledge !== 1'b0) begin bad++; $display("FAIL rd_ack1 got=%b exp=0", m1_acknowledge); end
    total++; if (m0_read_data !== 16'h0080) begin bad++; $display("FAIL rd_data got=%h exp=0080", m0_read_data); end
    total++; if (s_bus_enable !== 1'b0) begin bad++; $display("FAIL rd_sbe_drop got=%b exp=0", s_bus_enable); end
    s_acknowledge = 1'b0; s_read_data = 16'h0; m0_bus_enable = 1'b0;
    @(negedge clk_clk);
    total++; if (m0_acknowledge !== 1'b0) begin bad++; $display("FAIL rd_pulse got=%b exp=0", m0_acknowledge); end
    total++; if (m0_read_data !== 16'h0080) begin bad++; $display("FAIL rd_hold got=%h exp=0080", m0_read_data); end
  endtask

  task automatic test_write();
    m1_address = 16'h2006; m1_write_data = 16'h3F21; m1_byte_enable = 2'b01; m1_rw = 1'b0;
    m1_bus_enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_clk);
      total++;
      if ({s_bus_enable, s_address, s_byte_enable, s_rw, s_write_data} !== {1'b1, 16'h2006, 2'b01, 1'b0, 16'h3F21})
        begin bad++; $display("FAIL wr_s_cyc%0d got=%h exp=%h", k,
          {s_bus_enable, s_address, s_byte_enable, s_rw, s_write_data}, {1'b1, 16'h2006, 2'b01, 1'b0, 16'h3F21}); end
      if (k == 2) begin
        m0_address = 16'hAAAA; m0_write_data = 16'h5555; m0_rw = 1'b0; m0_bus_enable = 1'b1;
      end
    end
    s_acknowledge = 1'b1; s_read_data = 16'hBEEF;
    @(negedge clk_clk);
    total++; if (m1_acknowledge !== 1'b1) begin bad++; $display("FAIL wr_ack1 got=%b exp=1", m1_acknowledge); end
    total++; if (m0_acknowledge !== 1'b0) begin bad++; $display("FAIL wr_ack0 got=%b exp=0", m0_acknowledge); end
    total++; if (m0_read_data !== 16'h0080) begin bad++; $display("FAIL wr_m0hold got=%h exp=0080", m0_read_data); end
    s_acknowledge = 1'b0; m1_bus_enable = 1'b0; m0_bus_enable = 1'b0;
    @(negedge clk_clk);
  endtask

  task automatic test_tie();
    int          win [3] = '{0, 1, 0};
    logic [15:0] dat [3] = '{16'h1111, 16'h2222, 16'h5A5A};
    reset_reset_n = 1'b0;
    m0_address = 16'h0100; m0_rw = 1'b1; m0_bus_enable = 1'b1;
    m1_address = 16'h0200; m1_rw = 1'b1; m1_bus_enable = 1'b1;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_clk);
      total++;
      if (s_address !== ((win[i] == 1) ? 16'h0200 : 16'h0100))
        begin bad++; $display("FAIL tie_grant%0d got=%h exp_req=%0d", i, s_address, win[i]); end
      s_acknowledge = 1'b1; s_read_data = dat[i];
      @(negedge clk_clk);
      total++;
      if ({m1_acknowledge, m0_acknowledge} !== ((win[i] == 1) ? 2'b10 : 2'b01))
        begin bad++; $display("FAIL tie_ack%0d got=%b exp_req=%0d", i, {m1_acknowledge, m0_acknowledge}, win[i]); end
      s_acknowledge = 1'b0;
      if (i == 2) begin m0_bus_enable = 1'b0; m1_bus_enable = 1'b0; end
      @(negedge clk_clk);
    end
    total++; if (m0_read_data !== 16'h5A5A) begin bad++; $display("FAIL tie_rd0 got=%h exp=5a5a", m0_read_data); end
    total++; if (m1_read_data !== 16'h2222) begin bad++; $display("FAIL tie_rd1 got=%h exp=2222", m1_read_data); end
  endtask

  task automatic test_timeout();
    m0_address = 16'h1000; m0_rw = 1'b1; m0_bus_enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_clk);
      total++; if (s_bus_enable !== 1'b1) begin bad++; $display("FAIL to_sbe_cyc%0d got=%b exp=1", k, s_bus_enable); end
    end
    @(negedge clk_clk);
    total++; if (s_bus_enable !== 1'b0) begin bad++; $display("FAIL to_sbe_drop got=%b exp=0", s_bus_enable); end
    total++; if (m0_acknowledge !== 1'b1) begin bad++; $display("FAIL to_ack got=%b exp=1", m0_acknowledge); end
    total++; if (m0_read_data !== 16'h0000) begin bad++; $display("FAIL to_data got=%h exp=0000", m0_read_data); end
    total++; if (timeout_irq !== 1'b1) begin bad++; $display("FAIL to_irq got=%b exp=1", timeout_irq); end
    m0_bus_enable = 1'b0;
    repeat (3) @(negedge clk_clk);
    total++; if (timeout_irq !== 1'b1) begin bad++; $display("FAIL to_irq_sticky got=%b exp=1", timeout_irq); end
    timeout_clear = 1'b1;
    @(negedge clk_clk);
    timeout_clear = 1'b0;
    total++; if (timeout_irq !== 1'b0) begin bad++; $display("FAIL to_irq_clr got=%b exp=0", timeout_irq); end
  endtask

  task automatic test_ack_at_timeout();
    m1_address = 16'h3000; m1_rw = 1'b1; m1_bus_enable = 1'b1;
    repeat (8) @(negedge clk_clk);
    total++; if (s_bus_enable !== 1'b1) begin bad++; $display("FAIL at_sbe8 got=%b exp=1", s_bus_enable); end
    s_acknowledge = 1'b1; s_read_data = 16'h1234;
    @(negedge clk_clk);
    total++; if (m1_acknowledge !== 1'b1) begin bad++; $display("FAIL at_ack got=%b exp=1", m1_acknowledge); end
    total++; if (m1_read_data !== 16'h1234) begin bad++; $display("FAIL at_data got=%h exp=1234", m1_read_data); end
    total++; if (timeout_irq !== 1'b0) begin bad++; $display("FAIL at_irq got=%b exp=0", timeout_irq); end
    s_acknowledge = 1'b0; m1_bus_enable = 1'b0;
    @(negedge clk_clk);
  endtask

  task automatic test_ack_ignored();
    s_acknowledge = 1'b1; s_read_data = 16'hFFFF;
    repeat (2) @(negedge clk_clk);
    total++;
    if ({m0_acknowledge, m1_acknowledge, s_bus_enable} !== 3'b000)
      begin bad++; $display("FAIL ign_ack got=%b exp=000", {m0_acknowledge, m1_acknowledge, s_bus_enable}); end
    total++; if (m1_read_data !== 16'h1234) begin bad++; $display("FAIL ign_hold got=%h exp=1234", m1_read_data); end
    s_acknowledge = 1'b0; s_read_data = 16'h0;
    @(negedge clk_clk);
  endtask

  task automatic test_reset_mid_busy();
    // finish an m0 transfer so an unreset arbiter would favour m1 next
    m0_address = 16'h4000; m0_bus_enable = 1'b1;
    @(negedge clk_clk);
    s_acknowledge = 1'b1; s_read_data = 16'h7777;
    @(negedge clk_clk);
    s_acknowledge = 1'b0; m0_bus_enable = 1'b0;
    @(negedge clk_clk);
    m1_address = 16'h5000; m1_bus_enable = 1'b1;
    @(negedge clk_clk);
    total++; if (s_address !== 16'h5000) begin bad++; $display("FAIL rst_pre got=%h exp=5000", s_address); end
    m0_bus_enable = 1'b1;
    #2 reset_reset_n = 1'b0;
    #1;
    total++;
    if ({s_bus_enable, s_address, s_byte_enable, s_rw, s_write_data} !== 36'h0)
      begin bad++; $display("FAIL rst_s got=%h exp=0", {s_bus_enable, s_address, s_byte_enable, s_rw, s_write_data}); end
    total++;
    if ({m0_acknowledge, m1_acknowledge, m0_read_data, m1_read_data, timeout_irq} !== 35'h0)
      begin bad++; $display("FAIL rst_m got=%h exp=0", {m0_acknowledge, m1_acknowledge, m0_read_data, m1_read_data, timeout_irq}); end
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    total++; if ({m0_acknowledge, m1_acknowledge} !== 2'b00) begin bad++; $display("FAIL rst_noack got=%b exp=00", {m0_acknowledge, m1_acknowledge}); end
    total++; if (s_address !== 16'h4000) begin bad++; $display("FAIL rst_tie got=%h exp=4000", s_address); end
    s_acknowledge = 1'b1; s_read_data = 16'h9999;
    @(negedge clk_clk);
    total++; if ({m1_acknowledge, m0_acknowledge} !== 2'b01) begin bad++; $display("FAIL rst_ack got=%b exp=01", {m1_acknowledge, m0_acknowledge}); end
    s_acknowledge = 1'b0; m0_bus_enable = 1'b0; m1_bus_enable = 1'b0;
    @(negedge clk_clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_tie();
    test_timeout();
    test_ack_at_timeout();
    test_ack_ignored();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
